// File: rtl/seq_mult8x8_nibble.sv
// Sequential 8x8 unsigned multiplier built on one 4x4 Wallace tree.
// The tree is reused for four nibble products that are summed in order.

module wallacetree4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);

  function automatic logic [1:0] ha(
    input logic x,
    input logic y
  );
    ha = {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(
    input logic x,
    input logic y,
    input logic z
  );
    fa = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // w_pp[i][j] carries weight i+j
  logic [3:0][3:0] w_pp;

  // stage-1 sums/carries, named by column
  logic w_s1, w_c1;
  logic w_s2, w_c2;
  logic w_s3, w_c3;
  logic w_s4, w_c4;
  logic w_s5, w_c5;

  // stage-2 sums/carries, named by column
  logic w_t3, w_k4;
  logic w_t4, w_k5;
  logic w_t5, w_k6;
  logic w_t6, w_k7;

  // final carry-propagate rows for columns 2..7
  logic [5:0] w_x;
  logic [5:0] w_y;
  logic [5:0] w_sum;

  // partial-product array
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_pp[i][j] = a[j] & b[i];
      end
    end
  end

  assign {w_c1, w_s1} = ha(w_pp[0][1], w_pp[1][0]);
  assign {w_c2, w_s2} = fa(w_pp[0][2], w_pp[1][1], w_pp[2][0]);
  assign {w_c3, w_s3} = fa(w_pp[0][3], w_pp[1][2], w_pp[2][1]);
  assign {w_c4, w_s4} = fa(w_pp[1][3], w_pp[2][2], w_pp[3][1]);
  assign {w_c5, w_s5} = ha(w_pp[2][3], w_pp[3][2]);

  assign {w_k4, w_t3} = fa(w_s3, w_c2, w_pp[3][0]);
  assign {w_k5, w_t4} = ha(w_s4, w_c3);
  assign {w_k6, w_t5} = ha(w_s5, w_c4);
  assign {w_k7, w_t6} = ha(w_pp[3][3], w_c5);

  assign w_x   = {w_k7, w_t6, w_t5, w_t4, w_t3, w_s2};
  assign w_y   = {1'b0, w_k6, w_k5, w_k4, 1'b0, w_c1};
  assign w_sum = w_x + w_y;

  assign prod = {w_sum, w_s1, w_pp[0][0]};

endmodule

module seq_mult8x8_nibble (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic [1:0]  r_step;

  logic        w_accept;
  logic        w_calc;
  logic [3:0]  w_ta;
  logic [3:0]  w_tb;
  logic [7:0]  w_tp;
  logic [15:0] w_term;

  wallacetree4x4 u_tree (
    .a    (w_ta),
    .b    (w_tb),
    .prod (w_tp)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CALC;
      S_CALC:  if (r_step == 2'd3) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  assign w_accept = in_ready & in_valid;
  assign w_calc   = (r_state == S_CALC);

  // nibble selection and weighting for the current step
  always_comb begin
    w_ta   = r_a[3:0];
    w_tb   = r_b[3:0];
    w_term = {8'h00, w_tp};
    unique case (r_step)
      2'd0: begin
        w_ta   = r_a[3:0];
        w_tb   = r_b[3:0];
        w_term = {8'h00, w_tp};
      end
      2'd1: begin
        w_ta   = r_a[7:4];
        w_tb   = r_b[3:0];
        w_term = {4'h0, w_tp, 4'h0};
      end
      2'd2: begin
        w_ta   = r_a[3:0];
        w_tb   = r_b[7:4];
        w_term = {4'h0, w_tp, 4'h0};
      end
      2'd3: begin
        w_ta   = r_a[7:4];
        w_tb   = r_b[7:4];
        w_term = {w_tp, 8'h00};
      end
      default: begin
        w_ta   = r_a[3:0];
        w_tb   = r_b[3:0];
        w_term = {8'h00, w_tp};
      end
    endcase
  end

  // operand capture, accumulation and step count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_acc  <= 16'h0000;
      r_step <= 2'd0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= 16'h0000;
      r_step <= 2'd0;
    end else if (w_calc) begin
      r_acc  <= r_acc + w_term;
      r_step <= r_step + 2'd1;
    end
  end

  assign prod = r_acc;

endmodule

// File: doc/seq_mult8x8_nibble.md
SEQ_MULT8X8_NIBBLE -- requirements
Module: seq_mult8x8_nibble

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  8  unsigned multiplicand.
REQ-007 b  input  8  unsigned multiplier.
REQ-008 out_valid  output  1  prod holds a completed result.
REQ-009 out_ready  input  1  downstream accepts prod.
REQ-010 prod  output  16  unsigned product a*b.
REQ-011 busy  output  1  high in CALC or DONE.

Function
REQ-012 The block SHALL contain exactly one instance of the combinational 4x4 Wallace tree multiplier wallacetree4x4 (a[3:0], b[3:0] -> prod[7:0]), reused over four cycles per operation.
REQ-013 FSM states SHALL be IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
REQ-014 Accept: on an edge with state==IDLE and in_valid=1, the block SHALL latch a and b into internal registers, clear the 16-bit accumulator, set step=0, and enter CALC.
REQ-015 CALC, step 0..3 (2-bit counter): the tree inputs SHALL be step0 (a_lo,b_lo) shift 0; step1 (a_hi,b_lo) shift 4; step2 (a_lo,b_hi) shift 4; step3 (a_hi,b_hi) shift 8.
REQ-016 Each CALC edge SHALL add the zero-extended, shifted 8-bit tree output to the accumulator modulo 2^16 (overflow cannot occur; max 0xFE01) and increment step.
REQ-017 On the step-3 edge the block SHALL enter DONE; out_valid SHALL first be high exactly 5 edges after the accept edge (acceptance edge + 4 CALC edges), i.e. fixed latency 5 cycles.
REQ-018 prod SHALL be driven directly from the accumulator register; while out_valid=1 and out_ready=0, prod and out_valid SHALL hold stable indefinitely.
REQ-019 DONE: on an edge with out_ready=1, the block SHALL return to IDLE; prod SHALL retain its value until the next accept.
REQ-020 The block SHALL NOT accept in the same edge a result is drained (no bypass); the minimum initiation interval is 6 cycles.
REQ-021 in_valid, a, b SHALL be ignored outside IDLE; latched operands SHALL NOT change during CALC/DONE even if a/b change.
REQ-022 out_ready SHALL be ignored outside DONE.

Reset
REQ-023 With rst=1 on an edge, the block SHALL go to IDLE, step=0, accumulator=0, operand registers=0; thus in_ready=1, out_valid=0, busy=0, prod=0x0000 after that edge.
REQ-024 rst SHALL take priority over every other input, including mid-CALC or in DONE with a pending result; the in-flight operation SHALL be discarded with no out_valid pulse.

Verification
REQ-025 rst, then a=0x12, b=0x34 accepted, out_ready=1 -> out_valid rises 5 edges later with prod=0x03A8, single-cycle pulse, in_ready returns next cycle.
REQ-026 a=0xFF, b=0xFF -> prod=0xFE01; a=0xA5, b=0x00 -> prod=0x0000; a=0x01, b=0x80 -> prod=0x0080.
REQ-027 a=0x0F, b=0xF0 with out_ready=0 for 10 cycles -> out_valid and prod=0x0E10 held stable, in_ready=0 throughout; drains on first out_ready=1 edge.
REQ-028 rst asserted on 2nd CALC edge of a=0xFF, b=0xFF -> next cycle state IDLE, prod=0x0000, no out_valid; next accept of 0x03*0x05 -> prod=0x000F.
REQ-029 in_valid held high with a/b changing every cycle and out_ready=1 -> each result matches the operands sampled at its accept edge, accepts spaced exactly 6 cycles apart.
REQ-030 Random: 10,000 operand pairs with random in_valid/out_ready -> every prod equals a*b against a reference model, no lost or duplicated results.
